emergency_zone_ctrl: RTL and testbench

//  Multi-zone emergency controller. Generalises the single-sensor panic FSM to
//  NUM_ZONES sensors, adding:
//   - input sync + debounce
//   - per-zone enable, latched cause and per-zone door unlock
//   - operator acknowledge (SILENCED state)
//   - re-trigger from recovery
//   - saturating event counter

---
 rtl/emergency_zone_ctrl.sv | 168 ++++++++++++++++
 tb/tb_emergency_zone_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/emergency_zone_ctrl.sv
// Multi-zone emergency controller: synchronised, debounced panic/zone inputs drive a
// four-state FSM with latched causes, operator silence and registered active-low pins.
module emergency_zone_ctrl #(
    parameter int NUM_ZONES        = 4,
    parameter int DEBOUNCE_CYCLES  = 50_000,
    parameter int EMERG_MIN_CYCLES = 5_000_000,
    parameter int RECOVERY_CYCLES  = 10_000_000,
    parameter int CNT_W            = 24,
    parameter int FAST_BIT         = 22,
    parameter int SLOW_BIT         = 21
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 panic_n,
    input  logic [NUM_ZONES-1:0] zone_sense,
    input  logic [NUM_ZONES-1:0] zone_enable,
    input  logic                 ack,
    output logic                 alarm_n,
    output logic                 alert_light_n,
    output logic [NUM_ZONES-1:0] door_unlock_n,
    output logic                 call_help_n,
    output logic [NUM_ZONES-1:0] cause_zones,
    output logic                 cause_panic,
    output logic [1:0]           fsm_state,
    output logic [7:0]           event_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EMERG = 2'd1;
    localparam logic [1:0] S_SIL   = 2'd2;
    localparam logic [1:0] S_REC   = 2'd3;

    localparam int NIN  = NUM_ZONES + 1;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EMERG_LAST = CNT_W'(EMERG_MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOVERY_CYCLES - 1);
    // Panic sits in the top bit; its idle level is high, zones idle low.
    localparam logic [NIN-1:0]   IN_IDLE    = {1'b1, {NUM_ZONES{1'b0}}};

    logic [NIN-1:0]           raw_in;
    logic [NIN-1:0]           sync_a;
    logic [NIN-1:0]           sync_b;
    logic [NIN-1:0]           filt;
    logic [NIN-1:0][DB_W-1:0] db_cnt;

    logic                 panic_act;
    logic                 panic_prev;
    logic                 panic_ev;
    logic [NUM_ZONES-1:0] zact;
    logic                 trig;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] timer;
    logic             timer_clear;
    logic             enter_emerg_evt;
    logic             enter_idle;
    logic             latch_en;
    logic             active;

    assign raw_in = {panic_n, zone_sense};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= IN_IDLE;
            sync_b <= IN_IDLE;
        end else begin
            sync_a <= raw_in;
            sync_b <= sync_a;
        end
    end

    // A disagreeing input must persist DEBOUNCE_CYCLES cycles in a row to be accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt   <= IN_IDLE;
            db_cnt <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (sync_b[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync_b[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign panic_act = ~filt[NUM_ZONES];
    assign panic_ev  = panic_act & ~panic_prev;
    assign zact      = filt[NUM_ZONES-1:0] & zone_enable;
    assign trig      = panic_ev | (|zact);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (trig) next_state = S_EMERG;
            end
            S_EMERG: begin
                if (ack)                                      next_state = S_SIL;
                else if (timer >= EMERG_LAST && zact == '0)   next_state = S_REC;
            end
            S_SIL: begin
                if (panic_ev || |(zact & ~cause_zones))       next_state = S_EMERG;
                else if (timer >= EMERG_LAST && zact == '0)   next_state = S_REC;
            end
            default: begin
                if (trig)                   next_state = S_EMERG;
                else if (timer >= REC_LAST) next_state = S_IDLE;
            end
        endcase
    end

    // Silencing keeps the minimum-duration clock running so it cannot extend the event.
    assign timer_clear     = (next_state != state) && !(state == S_EMERG && next_state == S_SIL);
    assign enter_emerg_evt = (next_state == S_EMERG) && (state == S_IDLE || state == S_REC);
    assign enter_idle      = (next_state == S_IDLE) && (state != S_IDLE);
    assign latch_en        = (next_state == S_EMERG) || (state == S_EMERG) || (state == S_SIL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            panic_prev  <= 1'b0;
            cause_zones <= '0;
            cause_panic <= 1'b0;
            event_count <= '0;
        end else begin
            state      <= next_state;
            panic_prev <= panic_act;
            if (timer_clear)  timer <= '0;
            else if (~&timer) timer <= timer + 1'b1;
            if (enter_idle) begin
                cause_zones <= '0;
                cause_panic <= 1'b0;
            end else if (latch_en) begin
                cause_zones <= cause_zones | zact;
                cause_panic <= cause_panic | panic_ev;
            end
            if (enter_emerg_evt && event_count != 8'hFF) event_count <= event_count + 1'b1;
        end
    end

    assign active    = (state == S_EMERG) || (state == S_SIL);
    assign fsm_state = state;

    // Pins decode the previous cycle's state/timer so every output is a clean flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_n       <= 1'b1;
            alert_light_n <= 1'b1;
            call_help_n   <= 1'b1;
            door_unlock_n <= '1;
        end else begin
            alarm_n       <= !(state == S_EMERG && !timer[FAST_BIT]);
            alert_light_n <= active ? 1'b0 : (state == S_REC) ? ~timer[SLOW_BIT] : 1'b1;
            call_help_n   <= ~active;
            door_unlock_n <= active ? ~(cause_zones | {NUM_ZONES{cause_panic}}) : '1;
        end
    end

endmodule

// File: tb/tb_emergency_zone_ctrl.sv
// Directed bench for emergency_zone_ctrl using small timing parameters; each check is an
// immediate assertion against a hand-computed value.
module tb_emergency_zone_ctrl;

    logic       clk;
    logic       reset;
    logic       panic_n;
    logic [3:0] zone_sense;
    logic [3:0] zone_enable;
    logic       ack;
    logic       alarm_n;
    logic       alert_light_n;
    logic [3:0] door_unlock_n;
    logic       call_help_n;
    logic [3:0] cause_zones;
    logic       cause_panic;
    logic [1:0] fsm_state;
    logic [7:0] event_count;

    int checks   = 0;
    int failures = 0;

    emergency_zone_ctrl #(
        .NUM_ZONES(4), .DEBOUNCE_CYCLES(4), .EMERG_MIN_CYCLES(100),
        .RECOVERY_CYCLES(200), .CNT_W(10), .FAST_BIT(3), .SLOW_BIT(4)
    ) dut (
        .clk(clk), .reset(reset), .panic_n(panic_n), .zone_sense(zone_sense),
        .zone_enable(zone_enable), .ack(ack), .alarm_n(alarm_n),
        .alert_light_n(alert_light_n), .door_unlock_n(door_unlock_n),
        .call_help_n(call_help_n), .cause_zones(cause_zones), .cause_panic(cause_panic),
        .fsm_state(fsm_state), .event_count(event_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] zs, input logic pn, input logic [3:0] ze,
                                 input logic ak);
        zone_sense  = zs;
        panic_n     = pn;
        zone_enable = ze;
        ack         = ak;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitState(input logic [1:0] target, input int budget, input string tag);
        int n = 0;
        while (fsm_state !== target && n < budget) begin
            step(1);
            n++;
        end
        checkOutput(tag, 32'(fsm_state), 32'(target));
    endtask

    task automatic checkPinsIdle(input string tag);
        checkOutput({tag, "_state"}, 32'(fsm_state), 32'd0);
        checkOutput({tag, "_alarm"}, 32'(alarm_n), 32'd1);
        checkOutput({tag, "_alert"}, 32'(alert_light_n), 32'd1);
        checkOutput({tag, "_call"}, 32'(call_help_n), 32'd1);
        checkOutput({tag, "_door"}, 32'(door_unlock_n), 32'hF);
        checkOutput({tag, "_cz"}, 32'(cause_zones), 32'd0);
        checkOutput({tag, "_cp"}, 32'(cause_panic), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b0);
        step(3);
        checkPinsIdle("in_reset");
        checkOutput("in_reset_evt", 32'(event_count), 32'd0);
        reset = 1'b0;
        step(2);
        checkPinsIdle("post_reset");

        $display("[TB] glitch reject");
        applyStimulus(4'b0010, 1'b1, 4'hF, 1'b0);
        step(3);
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b0);
        step(12);
        checkPinsIdle("glitch");

        $display("[TB] zone event");
        applyStimulus(4'b0100, 1'b1, 4'hF, 1'b0);
        step(6);
        checkOutput("z_lat_pre", 32'(fsm_state), 32'd0);
        step(1);
        checkOutput("z_lat", 32'(fsm_state), 32'd1);
        checkOutput("z_cause", 32'(cause_zones), 32'b0100);
        checkOutput("z_evt", 32'(event_count), 32'd1);
        checkOutput("z_door_lag", 32'(door_unlock_n), 32'hF);
        step(1);
        checkOutput("z_door", 32'(door_unlock_n), 32'b1011);
        checkOutput("z_alarm_lo", 32'(alarm_n), 32'd0);
        checkOutput("z_call", 32'(call_help_n), 32'd0);
        checkOutput("z_alert", 32'(alert_light_n), 32'd0);
        step(8);
        checkOutput("z_alarm_hi", 32'(alarm_n), 32'd1);
        step(8);
        checkOutput("z_alarm_lo2", 32'(alarm_n), 32'd0);
        step(33);
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b0);
        step(49);
        checkOutput("z_min_hold", 32'(fsm_state), 32'd1);
        step(1);
        checkOutput("z_rec", 32'(fsm_state), 32'd3);
        step(1);
        checkOutput("z_rec_alert0", 32'(alert_light_n), 32'd1);
        checkOutput("z_rec_door", 32'(door_unlock_n), 32'hF);
        checkOutput("z_rec_call", 32'(call_help_n), 32'd1);
        checkOutput("z_rec_alarm", 32'(alarm_n), 32'd1);
        step(16);
        checkOutput("z_rec_blink", 32'(alert_light_n), 32'd0);
        step(182);
        checkOutput("z_rec_hold", 32'(fsm_state), 32'd3);
        step(1);
        checkPinsIdle("z_idle");
        checkOutput("z_idle_evt", 32'(event_count), 32'd1);

        $display("[TB] panic and ack");
        applyStimulus(4'b0000, 1'b0, 4'hF, 1'b0);
        step(7);
        checkOutput("p_state", 32'(fsm_state), 32'd1);
        checkOutput("p_cause", 32'(cause_panic), 32'd1);
        checkOutput("p_cz", 32'(cause_zones), 32'd0);
        checkOutput("p_evt", 32'(event_count), 32'd2);
        step(1);
        checkOutput("p_door", 32'(door_unlock_n), 32'h0);
        checkOutput("p_alarm", 32'(alarm_n), 32'd0);
        step(2);
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b1);
        step(1);
        checkOutput("p_sil", 32'(fsm_state), 32'd2);
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b0);
        step(1);
        checkOutput("p_sil_alarm", 32'(alarm_n), 32'd1);
        checkOutput("p_sil_call", 32'(call_help_n), 32'd0);
        checkOutput("p_sil_door", 32'(door_unlock_n), 32'h0);
        checkOutput("p_sil_alert", 32'(alert_light_n), 32'd0);
        step(95);
        checkOutput("p_rec", 32'(fsm_state), 32'd3);
        step(200);
        checkPinsIdle("p_idle");

        $display("[TB] escalation");
        applyStimulus(4'b0001, 1'b1, 4'hF, 1'b0);
        step(7);
        checkOutput("e_state", 32'(fsm_state), 32'd1);
        checkOutput("e_cz", 32'(cause_zones), 32'b0001);
        checkOutput("e_evt", 32'(event_count), 32'd3);
        applyStimulus(4'b0001, 1'b1, 4'hF, 1'b1);
        step(1);
        checkOutput("e_sil", 32'(fsm_state), 32'd2);
        applyStimulus(4'b1001, 1'b1, 4'hF, 1'b0);
        step(6);
        checkOutput("e_sil_hold", 32'(fsm_state), 32'd2);
        step(1);
        checkOutput("e_back", 32'(fsm_state), 32'd1);
        checkOutput("e_cz2", 32'(cause_zones), 32'b1001);
        checkOutput("e_evt2", 32'(event_count), 32'd3);
        step(1);
        checkOutput("e_tclr", 32'(alarm_n), 32'd0);
        checkOutput("e_door", 32'(door_unlock_n), 32'b0110);
        step(8);
        checkOutput("e_tclr_hi", 32'(alarm_n), 32'd1);
        applyStimulus(4'b0000, 1'b1, 4'hF, 1'b0);
        step(91);
        checkOutput("e_rec", 32'(fsm_state), 32'd3);

        $display("[TB] masking and retrigger");
        applyStimulus(4'b0001, 1'b1, 4'b1110, 1'b0);
        step(20);
        checkOutput("m_masked", 32'(fsm_state), 32'd3);
        checkOutput("m_evt", 32'(event_count), 32'd3);
        applyStimulus(4'b0011, 1'b1, 4'b1110, 1'b0);
        step(6);
        checkOutput("m_pre", 32'(fsm_state), 32'd3);
        step(1);
        checkOutput("m_retrig", 32'(fsm_state), 32'd1);
        checkOutput("m_evt2", 32'(event_count), 32'd4);
        checkOutput("m_cz", 32'(cause_zones), 32'b1011);
        step(2);
        checkOutput("m_door", 32'(door_unlock_n), 32'b0100);
        checkOutput("m_alarm", 32'(alarm_n), 32'd0);

        $display("[TB] async reset and saturation");
        #3;
        reset = 1'b1;
        #1;
        checkPinsIdle("ar");
        checkOutput("ar_evt", 32'(event_count), 32'd0);
        step(2);
        reset = 1'b0;
        step(6);
        checkOutput("ar_pre", 32'(fsm_state), 32'd0);
        step(1);
        checkOutput("ar_retrig", 32'(fsm_state), 32'd1);
        checkOutput("ar_evt2", 32'(event_count), 32'd1);
        for (int i = 0; i < 258; i++) begin
            applyStimulus(4'b0000, 1'b1, 4'b1110, 1'b0);
            waitState(2'd3, 150, "sat_rec");
            applyStimulus(4'b0010, 1'b1, 4'b1110, 1'b0);
            waitState(2'd1, 20, "sat_emerg");
            if (i == 99) checkOutput("sat_mid", 32'(event_count), 32'd101);
        end
        checkOutput("sat_final", 32'(event_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
